palette_arbiter: RTL and testbench

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/palette_pkg.sv | 26 ++
 rtl/palette_arbiter_rr_pick.sv | 47 ++++
 rtl/palette_arbiter.sv | 153 +++++++++++++++
 tb/tb_palette_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
// Module      : palette_pkg
// Description : Shared types and constants for the sprite palette arbiter:
//               colour/index types, the colour-key index, the arbiter FSM
//               state encoding and the default requester count.
// Revision    : 1.0  initial release
// ============================================================================
package palette_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [3:0]  pal_idx_t;

  // Palette entry used as the transparent colour key (hot pink 24'hff4295).
  localparam pal_idx_t TRANSPARENT_IDX = 4'h0;
  localparam rgb_t     COLORKEY_RGB    = 24'hff4295;

  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/palette_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin requester picker. Grants the first asserted
//               request at or after i_ptr (wrapping). When i_lock_en is set,
//               only i_lock_id may be granted, and only if it is requesting.
// Ports       : i_req     - request vector
//               i_ptr     - round-robin start position
//               i_lock_en - restrict the grant to i_lock_id
//               i_lock_id - locked requester
//               o_grant   - one-hot grant (all zero when nothing is granted)
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_lock_en,
  input  logic [ID_W-1:0]    i_lock_id,
  output logic [NUM_REQ-1:0] o_grant
);

  int   w_pos;
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_pos   = 0;
    if (i_lock_en) begin
      o_grant[i_lock_id] = i_req[i_lock_id];
    end else begin
      // Walk NUM_REQ positions starting at the pointer; first hit wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        w_pos = (int'(i_ptr) + k) % NUM_REQ;
        if (!w_found && i_req[w_pos]) begin
          o_grant[w_pos] = 1'b1;
          w_found        = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/palette_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : palette_arbiter
// Description : Shares one combinational palette lookup among NUM_REQ sprite
//               requesters. Round-robin arbitration with burst locking
//               (a requester keeps the grant until its req_last pixel), a
//               single registered output stage with valid/ready handshake,
//               sustaining one pixel per clock.
// Ports       : Clk, Reset_n (async, active-low)
//               req_valid/req_index/req_last/req_ready - requester side
//               pal_index/pal_rgb - external palette lookup
//               out_valid/out_ready/out_rgb/out_id/out_transparent - output
// Build macro : PALETTE_COLORKEY_EN - enables the out_transparent colour-key
//               flag; when undefined out_transparent is tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [4*NUM_REQ-1:0]       req_index,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [3:0]                 pal_index,
  input  logic [23:0]                pal_rgb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [23:0]                out_rgb,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_transparent
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]   r_lock_id, w_lock_id_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_gid;
  logic [ID_W-1:0]   w_ptr_inc;
  logic              w_free;
  logic              w_xfer;
  logic              w_last;
  pal_idx_t          w_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .i_lock_en (r_state == ST_BURST),
    .i_lock_id (r_lock_id),
    .o_grant   (w_grant)
  );

  // The output register can take a pixel when empty or draining this cycle.
  assign w_free = !out_valid || out_ready;

  // Reset_n gating keeps req_ready low while reset is held.
  assign req_ready = (w_free && Reset_n) ? w_grant : '0;

  // The picker only grants valid requesters, so any ready bit is a transfer.
  assign w_xfer = |req_ready;

  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gid = ID_W'(i);
    end
  end

  assign w_idx     = req_index[4*w_gid +: 4];
  assign w_last    = req_last[w_gid];
  assign pal_index = w_xfer ? w_idx : 4'h0;
  assign w_ptr_inc = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_ARB;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  // FSM next state; the pointer advances only when a burst (or single) ends.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      ST_ARB: begin
        if (w_xfer) begin
          if (w_last) begin
            w_rr_ptr_nxt = w_ptr_inc;
          end else begin
            w_state_nxt   = ST_BURST;
            w_lock_id_nxt = w_gid;
          end
        end
      end
      ST_BURST: begin
        if (w_xfer && w_last) begin
          w_state_nxt  = ST_ARB;
          w_rr_ptr_nxt = w_ptr_inc;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Output stage: load on transfer, otherwise clear valid once drained.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_rgb   <= 24'h000000;
      out_id    <= '0;
    end else if (w_xfer) begin
      out_valid <= 1'b1;
      out_rgb   <= pal_rgb;
      out_id    <= w_gid;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PALETTE_COLORKEY_EN
  logic r_transparent;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_transparent <= 1'b0;
    end else if (w_xfer) begin
      r_transparent <= (w_idx == TRANSPARENT_IDX);
    end
  end

  assign out_transparent = r_transparent;
`else
  assign out_transparent = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_palette_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_palette_arbiter
// Description : Directed self-checking bench for palette_arbiter (NUM_REQ=4)
//               with a combinational palette stub.
// Revision    : 1.0  initial release
// ============================================================================
module tb_palette_arbiter;

  localparam int NUM_REQ = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_index;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  pal_index;
  logic [23:0] pal_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic [1:0]  out_id;
  logic        out_transparent;

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 Clk = ~Clk;

  palette_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .req_valid       (req_valid),
    .req_index       (req_index),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .pal_index       (pal_index),
    .pal_rgb         (pal_rgb),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rgb         (out_rgb),
    .out_id          (out_id),
    .out_transparent (out_transparent)
  );

  function automatic logic [23:0] pal_lut(input logic [3:0] idx);
    case (idx)
      4'h0:    pal_lut = 24'hff4295;
      4'h1:    pal_lut = 24'h7a785a;
      4'h5:    pal_lut = 24'h1c1c03;
      default: pal_lut = {4'hA, idx, 4'h5, idx, 4'hC, idx};
    endcase
  endfunction

  assign pal_rgb = pal_lut(pal_index);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idx(input int r, input logic [3:0] v);
    req_index[4*r +: 4] = v;
  endtask

  task automatic reset_pulse;
    Reset_n = 1'b0;
    #1;
    Reset_n = 1'b1;
    #1;
  endtask

  logic [3:0] burst_seq [4];

  initial begin
    burst_seq[0] = 4'h4; burst_seq[1] = 4'h6; burst_seq[2] = 4'h7; burst_seq[3] = 4'h8;
    Reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_index = 16'h0;
    req_last  = 4'b1111;
    out_ready = 1'b1;

    // Reset state (requests present must not be accepted)
    tick;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_rgb",   {8'd0, out_rgb}, 32'h0);
    check("rst_out_id",    {30'd0, out_id}, 32'd0);
    check("rst_transp",    {31'd0, out_transparent}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    Reset_n   = 1'b1;
    req_valid = 4'b0000;
    tick;

    // Single request, index 1 -> 7a785a one clock later
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    set_idx(0, 4'h1);
    #1;
    check("single_ready", {28'd0, req_ready}, 32'h1);
    check("single_pal_idx", {28'd0, pal_index}, 32'h1);
    tick;
    req_valid = 4'b0000;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_rgb", {8'd0, out_rgb}, 32'h7a785a);
    check("single_id", {30'd0, out_id}, 32'd0);
    #1;
    check("idle_pal_idx", {28'd0, pal_index}, 32'h0);
    tick;
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Contention 0/2 from rr_ptr=0: grants alternate 0,2,0,2
    reset_pulse;
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    set_idx(0, 4'h2);
    set_idx(2, 4'h3);
    for (int n = 0; n < 4; n++) begin
      #1;
      check("cont_ready", {28'd0, req_ready}, (n % 2 == 0) ? 32'h1 : 32'h4);
      tick;
      check("cont_valid", {31'd0, out_valid}, 32'd1);
      check("cont_id", {30'd0, out_id}, (n % 2 == 0) ? 32'd0 : 32'd2);
      check("cont_rgb", {8'd0, out_rgb}, {8'd0, pal_lut((n % 2 == 0) ? 4'h2 : 4'h3)});
    end

    // Backpressure: hold for 3 cycles, then drain + accept together
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("bp_ready", {28'd0, req_ready}, 32'h0);
      tick;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_rgb", {8'd0, out_rgb}, {8'd0, pal_lut(4'h3)});
      check("bp_id", {30'd0, out_id}, 32'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, req_ready}, 32'h1);
    tick;
    check("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_b2b_id", {30'd0, out_id}, 32'd0);
    check("bp_b2b_rgb", {8'd0, out_rgb}, {8'd0, pal_lut(4'h2)});
    req_valid = 4'b0000;
    tick;
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Burst lock: requester 1 sends 4 pixels while 3 waits (3's last ignored)
    req_valid = 4'b1010;
    req_last  = 4'b1000;
    set_idx(3, 4'h9);
    for (int p = 0; p < 4; p++) begin
      set_idx(1, burst_seq[p]);
      req_last[1] = (p == 3);
      #1;
      check("burst_ready", {28'd0, req_ready}, 32'h2);
      tick;
      check("burst_id", {30'd0, out_id}, 32'd1);
      check("burst_rgb", {8'd0, out_rgb}, {8'd0, pal_lut(burst_seq[p])});
      if (p == 1) begin
        // locked requester stalls: nobody is granted
        req_valid = 4'b1000;
        #1;
        check("burst_hold_ready", {28'd0, req_ready}, 32'h0);
        tick;
        check("burst_hold_valid", {31'd0, out_valid}, 32'd0);
        req_valid = 4'b1010;
      end
    end
    req_valid = 4'b1000;
    #1;
    check("after_burst_ready", {28'd0, req_ready}, 32'h8);
    tick;
    check("after_burst_id", {30'd0, out_id}, 32'd3);
    check("after_burst_rgb", {8'd0, out_rgb}, {8'd0, pal_lut(4'h9)});

    // Reset in the middle of a burst
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    set_idx(1, 4'hB);
    tick;
    check("mid_p1_valid", {31'd0, out_valid}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {28'd0, req_ready}, 32'h0);
    Reset_n   = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("mid_unlocked", {28'd0, req_ready}, 32'h8);
    req_valid = 4'b1010;
    #1;
    check("mid_first_grant", {28'd0, req_ready}, 32'h2);
    tick;
    check("mid_first_id", {30'd0, out_id}, 32'd1);
    req_valid = 4'b0000;
    reset_pulse;

    // Colour key
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    set_idx(0, 4'h0);
    #1;
    tick;
    check("ck0_rgb", {8'd0, out_rgb}, 32'hff4295);
`ifdef PALETTE_COLORKEY_EN
    check("ck0_transp", {31'd0, out_transparent}, 32'd1);
`else
    check("ck0_transp", {31'd0, out_transparent}, 32'd0);
`endif
    set_idx(0, 4'h5);
    #1;
    tick;
    check("ck5_rgb", {8'd0, out_rgb}, 32'h1c1c03);
    check("ck5_transp", {31'd0, out_transparent}, 32'd0);
    req_valid = 4'b0000;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
